// File: rtl/kj_sync_tx.sv
// kj_sync_tx: K/J symbol-link frame transmitter.
// A word accepted on the valid/ready handshake is sent as one frame:
// an alternating K/J preamble, then the payload MSB first, then an idle gap.
// All outputs are registered. Each output register holds the symbol for the
// cycle after the edge, so the first K is visible right after the handshake.
// Optional build macro KJ_TX_ERR_INJ_EN adds the inj_err input. When it is
// sampled high at the handshake, the last preamble symbol of that frame is
// inverted, which lets a downstream detector's sync-error path be exercised.
module kj_sync_tx #(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = 4,
  parameter int GAP_LEN  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
`ifdef KJ_TX_ERR_INJ_EN
  input  logic              inj_err,
`endif
  output logic              data_ready,
  output logic              out_k,
  output logic              out_j,
  output logic              out_en,
  output logic              busy,
  output logic              frame_done
);

  // Counter widths; a 1-symbol phase still gets a 1-bit counter.
  localparam int SC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int BC_W = (DATA_W   > 1) ? $clog2(DATA_W)   : 1;
  localparam int GC_W = (GAP_LEN  > 1) ? $clog2(GAP_LEN)  : 1;

  localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_LEN - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
  localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  // One line symbol: K/J wires plus the enable qualifying them.
  typedef struct packed {
    logic k;
    logic j;
    logic en;
  } sym_t;

  // Preamble symbol idx: even -> K, odd -> J. The last one flips when injecting.
  function automatic sym_t sync_sym(input logic [SC_W-1:0] idx, input logic inj);
    sym_t s;
    logic is_k;
    is_k = ~idx[0];
    if (inj && (idx == SYNC_LAST)) is_k = ~is_k;
    s.k  = is_k;
    s.j  = ~is_k;
    s.en = 1'b1;
    return s;
  endfunction

  // Payload bit b is sent as (b, b).
  function automatic sym_t data_sym(input logic b);
    sym_t s;
    s.k  = b;
    s.j  = b;
    s.en = 1'b1;
    return s;
  endfunction

  state_t            state, state_d;
  logic [SC_W-1:0]   sync_cnt, sync_cnt_d;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_d;
  logic [GC_W-1:0]   gap_cnt, gap_cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  sym_t              sym_q, sym_d;
  logic              busy_d, done_d, ready_d;
  logic              inj_q;

`ifdef KJ_TX_ERR_INJ_EN
  logic inj_d;

  // Injection request captured at the handshake and held for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) inj_q <= 1'b0;
    else      inj_q <= inj_d;
  end
`else
  assign inj_q = 1'b0;
`endif

  // Next-state, counters, shift register and the symbol for the next cycle.
  always_comb begin
    state_d    = state;
    sync_cnt_d = sync_cnt;
    bit_cnt_d  = bit_cnt;
    gap_cnt_d  = gap_cnt;
    shreg_d    = shreg;
    sym_d      = '0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    ready_d    = 1'b0;
`ifdef KJ_TX_ERR_INJ_EN
    inj_d      = inj_q;
`endif
    case (state)
      IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (data_valid) begin
          state_d    = SYNC;
          sync_cnt_d = '0;
          shreg_d    = data_in;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
`ifdef KJ_TX_ERR_INJ_EN
          inj_d      = inj_err;
          sym_d      = sync_sym('0, inj_err);
`else
          sym_d      = sync_sym('0, 1'b0);
`endif
        end
      end
      SYNC: begin
        if (sync_cnt == SYNC_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          sym_d     = data_sym(shreg[DATA_W-1]);
          shreg_d   = shreg << 1;
        end else begin
          sync_cnt_d = sync_cnt + 1'b1;
          sym_d      = sync_sym(sync_cnt_d, inj_q);
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          // Payload done: first gap cycle, line idle, pulse frame_done.
          state_d   = GAP;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
          sym_d     = data_sym(shreg[DATA_W-1]);
          shreg_d   = shreg << 1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, counters, payload and registered outputs; reset idles the line at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      sync_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      sym_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      state      <= state_d;
      sync_cnt   <= sync_cnt_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      shreg      <= shreg_d;
      sym_q      <= sym_d;
      busy       <= busy_d;
      frame_done <= done_d;
      data_ready <= ready_d;
    end
  end

  assign out_k  = sym_q.k;
  assign out_j  = sym_q.j;
  assign out_en = sym_q.en;

endmodule

// File: tb/tb_kj_sync_tx.sv
// tb_kj_sync_tx: randomized self-checking bench for kj_sync_tx.
// A default-parameter instance plus a minimal (DATA_W=1, SYNC_LEN=2,
// GAP_LEN=1) instance. Expected line state per cycle after a handshake comes
// from a frame-position model. Vector order: {k, j, en, busy, frame_done, ready}.
module tb_kj_sync_tx;

  localparam int DW = 8, SL = 4, GL = 2;
  localparam int FL = SL + DW + GL;          // handshake to next ready
  localparam logic [5:0] IDLE_V = 6'b000001;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          inj_err = 1'b0;
  logic          data_ready, out_k, out_j, out_en, busy, frame_done;

  logic [0:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, s_k, s_j, s_en, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  kj_sync_tx #(.DATA_W(DW), .SYNC_LEN(SL), .GAP_LEN(GL)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
`ifdef KJ_TX_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .data_ready(data_ready), .out_k(out_k), .out_j(out_j), .out_en(out_en),
    .busy(busy), .frame_done(frame_done)
  );

  kj_sync_tx #(.DATA_W(1), .SYNC_LEN(2), .GAP_LEN(1)) dut_s (
    .CLK(CLK), .RST(RST), .data_in(s_data), .data_valid(s_valid),
`ifdef KJ_TX_ERR_INJ_EN
    .inj_err(1'b0),
`endif
    .data_ready(s_ready), .out_k(s_k), .out_j(s_j), .out_en(s_en),
    .busy(s_busy), .frame_done(s_done)
  );

  wire [5:0] obs   = {out_k, out_j, out_en, busy, frame_done, data_ready};
  wire [5:0] obs_s = {s_k, s_j, s_en, s_busy, s_done, s_ready};

  // Expected outputs in cycle i (1-based) after the handshake edge of word w.
  function automatic logic [5:0] model(input int s, input int d, input int g,
                                       input logic [31:0] w, input bit inj, input int i);
    logic k, j, en, bsy, fd, rdy;
    {k, j, en, bsy, fd, rdy} = 6'b0;
    if (i <= s) begin
      k = (i % 2 == 1);
      if (inj && i == s) k = !k;
      j = !k; en = 1'b1; bsy = 1'b1;
    end else if (i <= s + d) begin
      k = w[d - (i - s)]; j = k; en = 1'b1; bsy = 1'b1;
    end else if (i <= s + d + g) begin
      bsy = 1'b1; fd = (i == s + d + 1);
    end else begin
      rdy = 1'b1;
    end
    return {k, j, en, bsy, fd, rdy};
  endfunction

  task automatic test_reset();
    RST = 1'b0; data_valid = 1'b1; data_in = DW'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL reset cyc%0d got=%b exp=%b", c, obs, IDLE_V);
      end
    end
    data_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  // One frame; valid dropped after the handshake and data_in scrambled mid-frame.
  task automatic test_single_frame(input logic [DW-1:0] w, input bit inj);
    logic [5:0] e;
    data_in = w; data_valid = 1'b1; inj_err = inj;
    for (int i = 1; i <= FL + 1; i++) begin
      @(negedge CLK);
      e = model(SL, DW, GL, 32'(w), inj, i);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL frame w=%h inj=%0d cyc%0d got=%b exp=%b", w, inj, i, obs, e);
      end
      data_valid = 1'b0; inj_err = 1'b0;
      data_in = DW'($urandom);
    end
  endtask

  // valid held high: FF then 00, next preamble right after the ready cycle.
  task automatic test_back_to_back();
    logic [5:0] e;
    data_in = 8'hFF; data_valid = 1'b1;
    for (int i = 1; i <= FL + 1; i++) begin
      @(negedge CLK);
      e = model(SL, DW, GL, 32'hFF, 1'b0, i);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_first cyc%0d got=%b exp=%b", i, obs, e);
      end
      data_in = (i == FL + 1) ? 8'h00 : DW'($urandom);
    end
    for (int i = 1; i <= FL + 1; i++) begin
      @(negedge CLK);
      e = model(SL, DW, GL, 32'h00, 1'b0, i);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_second cyc%0d got=%b exp=%b", i, obs, e);
      end
      data_valid = 1'b0;
      data_in = DW'($urandom);
    end
  endtask

  // Reset during payload bit 3: line must idle before the next edge, no pulse.
  task automatic test_reset_mid();
    logic [DW-1:0] w;
    logic [5:0] e;
    w = DW'($urandom);
    data_in = w; data_valid = 1'b1;
    for (int i = 1; i <= SL + 4; i++) begin
      @(negedge CLK);
      e = model(SL, DW, GL, 32'(w), 1'b0, i);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rstmid_pre cyc%0d got=%b exp=%b", i, obs, e);
      end
      data_valid = 1'b0;
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rstmid_async got=%b exp=%b", obs, IDLE_V);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL rstmid_hold cyc%0d got=%b exp=%b", c, obs, IDLE_V);
      end
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rstmid_release got=%b exp=%b", obs, IDLE_V);
    end
    test_single_frame(8'h3C, 1'b0);
  endtask

  // Minimal-parameter instance: 10, 01, b b, one gap cycle, then ready.
  task automatic test_sweep(input logic b);
    logic [5:0] e;
    s_data = b; s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      e = model(2, 1, 1, {31'b0, b}, 1'b0, i);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL sweep b=%0d cyc%0d got=%b exp=%b", b, i, obs_s, e);
      end
      s_valid = 1'b0;
      s_data = 1'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hA5, 1'b0);
    for (int n = 0; n < 4; n++) test_single_frame(DW'($urandom), 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_sweep(1'b1);
    test_sweep(1'b0);
    test_sweep(1'($urandom));
`ifdef KJ_TX_ERR_INJ_EN
    test_single_frame(8'hA5, 1'b1);
    test_single_frame(8'hA5, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
